// File: rtl/bsu_pkg.sv
// Shared types for block_select_unit: request opcodes and flush FSM states.
package bsu_pkg;

    typedef enum logic [1:0] {
        OP_LOOKUP = 2'b00,
        OP_ALLOC  = 2'b01,
        OP_INVAL  = 2'b10,
        OP_RSVD   = 2'b11
    } op_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } state_e;

endpackage

// File: rtl/bsu_onehot_dec.sv
// Combinational ADDR_W -> 2**ADDR_W one-hot decoder.
module bsu_onehot_dec #(
    parameter int ADDR_W = 7
) (
    input  logic [ADDR_W-1:0]      addr,
    output logic [(2**ADDR_W)-1:0] sel
);

    always_comb begin
        sel       = '0;
        sel[addr] = 1'b1;
    end

endmodule

// File: rtl/block_select_unit.sv
// Block select unit: one-cycle lookup/allocate/invalidate against a valid-bit table.
// Optional invalidate-all sweep is built only when BSU_FLUSH_EN is defined.
module block_select_unit
    import bsu_pkg::*;
#(
    parameter int ADDR_W = 7
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [ADDR_W-1:0]         in_addr,
    input  logic [1:0]                in_op,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [(2**ADDR_W)-1:0]    out_sel,
    output logic [ADDR_W-1:0]         out_addr,
    output logic                      out_hit,
    input  logic                      flush_req,
    output logic                      flush_busy,
    output logic [(2**ADDR_W)-1:0]    valid_mask
);

    localparam int LINES = 2**ADDR_W;

    logic              vld_p1;
    logic [ADDR_W-1:0] addr_p1;
    logic              hit_p1;
    logic [LINES-1:0]  mask;
    logic [LINES-1:0]  mask_next;
    logic [LINES-1:0]  dec_sel;
    logic              accept;
    logic              busy;
    logic              sweep_clr;
    logic [ADDR_W-1:0] sweep_idx;

    assign in_ready = (!vld_p1 || out_ready) && !busy;
    assign accept   = in_valid && in_ready;

`ifdef BSU_FLUSH_EN
    state_e            state;
    state_e            state_next;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] cnt_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // The sweep ends on its own after the last index; a new flush_req is ignored.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        sweep_clr  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (flush_req) begin
                    state_next = ST_SWEEP;
                    cnt_next   = '0;
                end
            end
            ST_SWEEP: begin
                sweep_clr = 1'b1;
                cnt_next  = cnt + ADDR_W'(1);
                if (&cnt) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign busy      = (state == ST_SWEEP);
    assign sweep_idx = cnt;
`else
    logic unused_flush;
    assign unused_flush = flush_req;
    assign busy         = 1'b0;
    assign sweep_clr    = 1'b0;
    assign sweep_idx    = '0;
`endif

    // Stage p0 -> p1: table update at the accept edge, hit captured before it.
    always_comb begin
        mask_next = mask;
        if (accept) begin
            case (op_e'(in_op))
                OP_ALLOC: mask_next[in_addr] = 1'b1;
                OP_INVAL: mask_next[in_addr] = 1'b0;
                default:  ;
            endcase
        end
        if (sweep_clr) mask_next[sweep_idx] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1  <= 1'b0;
            addr_p1 <= '0;
            hit_p1  <= 1'b0;
            mask    <= '0;
        end else begin
            mask <= mask_next;
            if (accept) begin
                vld_p1  <= 1'b1;
                addr_p1 <= in_addr;
                hit_p1  <= mask[in_addr];
            end else if (out_ready) begin
                vld_p1  <= 1'b0;
            end
        end
    end

    // Select is decoded from the held address, so it is stable under backpressure.
    bsu_onehot_dec #(.ADDR_W(ADDR_W)) u_dec (
        .addr (addr_p1),
        .sel  (dec_sel)
    );

    assign out_valid  = vld_p1;
    assign out_addr   = addr_p1;
    assign out_hit    = hit_p1;
    assign out_sel    = vld_p1 ? dec_sel : '0;
    assign flush_busy = busy;
    assign valid_mask = mask;

endmodule
